// File: rtl/debug_unit.sv
// -----------------------------------------------------------------------------
// debug_unit
//   Host-side sequencer for the BIP I. Receives a program over the UART byte by
//   byte (high byte first), writes each 16-bit word into program memory, then
//   releases the CPU soft reset. When the fetched opcode reads HLT (0) it
//   latches PC, accumulator and the executed-cycle count and sends them back
//   to the host as six bytes, most significant byte first.
//
// Ports
//   i_clock       system clock, rising edge
//   i_reset       asynchronous reset, active low
//   i_rx_data     received byte, valid while i_rx_done = 1
//   i_rx_done     one-cycle pulse per received byte
//   i_tx_done     one-cycle pulse when the transmitter finished a byte
//   i_opcode      opcode currently fetched by the control unit
//   i_pc          control unit program counter
//   i_acc         datapath accumulator
//   o_tx_data     byte to transmit (held stable until i_tx_done)
//   o_tx_start    one-cycle transmit start pulse
//   o_soft_reset  1 holds the CPU in reset; 0 only while running
//   o_wr_prog     program-memory write strobe
//   o_addr_prog   program-memory write address
//   o_data_prog   program-memory write data
//   o_state       current FSM state, for LEDs
// -----------------------------------------------------------------------------
module debug_unit #(
  parameter int          PC_CANT_BITS  = 11,
  parameter int          OPCODE_LENGTH = 5,
  parameter int          INSTR_LENGTH  = 16,
  parameter logic [7:0]  CMD_START     = 8'h01
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_done,
  input  logic                      i_tx_done,
  input  logic [OPCODE_LENGTH-1:0]  i_opcode,
  input  logic [PC_CANT_BITS-1:0]   i_pc,
  input  logic [INSTR_LENGTH-1:0]   i_acc,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_start,
  output logic                      o_soft_reset,
  output logic                      o_wr_prog,
  output logic [PC_CANT_BITS-1:0]   o_addr_prog,
  output logic [INSTR_LENGTH-1:0]   o_data_prog,
  output logic [2:0]                o_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WRITE   = 3'd3,
    RUN     = 3'd4,
    SEND    = 3'd5,
    WAIT_TX = 3'd6
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [PC_CANT_BITS-1:0]   addr;
  logic [INSTR_LENGTH-1:0]   instr;
  logic [15:0]               cycles;
  logic [15:0]               pc_lat;
  logic [15:0]               acc_lat;
  logic [2:0]                byte_idx;
  logic [7:0]                tx_byte;
  logic                      last_word;
  logic                      halted;

  // Saturating increment for the executed-cycle counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Loading stops at HLT or at the top of program memory; the address never wraps.
  assign last_word = (instr[INSTR_LENGTH-1 -: OPCODE_LENGTH] == '0) || (addr == '1);
  assign halted    = (i_opcode == '0);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    o_wr_prog    = 1'b0;
    o_tx_start   = 1'b0;
    o_soft_reset = 1'b1;
    case (state)
      IDLE: begin
        if (i_rx_done && (i_rx_data == CMD_START)) state_next = LOAD_HI;
      end
      LOAD_HI: begin
        if (i_rx_done) state_next = LOAD_LO;
      end
      LOAD_LO: begin
        if (i_rx_done) state_next = WRITE;
      end
      WRITE: begin
        o_wr_prog  = 1'b1;
        state_next = last_word ? RUN : LOAD_HI;
      end
      RUN: begin
        o_soft_reset = 1'b0;
        if (halted) state_next = SEND;
      end
      SEND: begin
        o_tx_start = 1'b1;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) state_next = (byte_idx == 3'd5) ? IDLE : SEND;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      addr     <= '0;
      instr    <= '0;
      cycles   <= '0;
      pc_lat   <= '0;
      acc_lat  <= '0;
      byte_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_rx_done && (i_rx_data == CMD_START)) addr <= '0;
        end
        LOAD_HI: begin
          if (i_rx_done) instr[INSTR_LENGTH-1 -: 8] <= i_rx_data;
        end
        LOAD_LO: begin
          if (i_rx_done) instr[7:0] <= i_rx_data;
        end
        WRITE: begin
          if (last_word) cycles <= '0;
          else           addr   <= addr + 1'b1;
        end
        RUN: begin
          // The HLT cycle itself is not counted.
          if (halted) begin
            pc_lat   <= 16'(i_pc);
            acc_lat  <= 16'(i_acc);
            byte_idx <= '0;
          end else begin
            cycles <= sat_inc(cycles);
          end
        end
        WAIT_TX: begin
          if (i_tx_done) byte_idx <= (byte_idx == 3'd5) ? 3'd0 : byte_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (byte_idx)
      3'd0:    tx_byte = pc_lat[15:8];
      3'd1:    tx_byte = pc_lat[7:0];
      3'd2:    tx_byte = acc_lat[15:8];
      3'd3:    tx_byte = acc_lat[7:0];
      3'd4:    tx_byte = cycles[15:8];
      3'd5:    tx_byte = cycles[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  assign o_tx_data   = ((state == SEND) || (state == WAIT_TX)) ? tx_byte : 8'h00;
  assign o_addr_prog = addr;
  assign o_data_prog = instr;
  assign o_state     = state;

endmodule
